// File: rtl/vga_timing_gen_pkg.sv
// 720x480p60 raster constants, counter widths and sync polarities shared by
// the timing generator and its consumers.
package vga_timing_pkg;

    localparam int H_ACTIVE = 720;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 62;
    localparam int H_BP     = 60;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 9;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 30;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HCNT_W  = 11;
    localparam int VCNT_W  = 10;
    localparam int COORD_W = 10;

    localparam logic HS_POL = 1'b0;
    localparam logic VS_POL = 1'b0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle driven by the raster generator into the pixel pipeline.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
();

    logic               hsync;
    logic               vsync;
    logic               de;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               frame_start;
    logic               line_start;

    modport master (
        output hsync, vsync, de, x, y, frame_start, line_start
    );

    modport slave (
        input  hsync, vsync, de, x, y, frame_start, line_start
    );

endinterface

// File: rtl/vga_timing_gen_sync_2ff.sv
// Generic two-flop synchronizer for slow level signals crossing into clk.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: lock-gated h/v counters with a registered decode of
// sync, data enable, coordinates and frame/line strobes.
module vga_timing_gen #(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic HS_POL   = vga_timing_pkg::HS_POL,
    parameter logic VS_POL   = vga_timing_pkg::VS_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    vga_timing_gen_if.master vo
);

    import vga_timing_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(H_TOT - 1);
    localparam logic [HCNT_W-1:0] H_ACT_N = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_BEG  = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END  = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(V_TOT - 1);
    localparam logic [VCNT_W-1:0] V_ACT_N = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] VS_BEG  = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END  = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic lock_s;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    // run_q marks that counters have sat at 0,0 for one locked cycle, so the
    // first decoded pixel is always the frame origin.
    logic               run_q;
    logic [HCNT_W-1:0]  h_q, h_d;
    logic [VCNT_W-1:0]  v_q, v_d;

    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               fs_q, fs_d;
    logic               ls_q, ls_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!lock_s) begin
            h_d = '0;
            v_d = '0;
        end else if (run_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decode of the current counters; registered below so every output shares
    // the same one-cycle latency.
    always_comb begin
        hsync_d = ~HS_POL;
        vsync_d = ~VS_POL;
        de_d    = 1'b0;
        x_d     = '0;
        y_d     = '0;
        fs_d    = 1'b0;
        ls_d    = 1'b0;
        if (lock_s && run_q) begin
            de_d    = (h_q < H_ACT_N) && (v_q < V_ACT_N);
            hsync_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
            vsync_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
            x_d     = de_d ? h_q[COORD_W-1:0] : '0;
            y_d     = de_d ? COORD_W'(v_q) : '0;
            ls_d    = (h_q == '0);
            fs_d    = (h_q == '0) && (v_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            run_q   <= lock_s;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
        end
    end

    assign vo.hsync       = hsync_q;
    assign vo.vsync       = vsync_q;
    assign vo.de          = de_q;
    assign vo.x           = x_q;
    assign vo.y           = y_q;
    assign vo.frame_start = fs_q;
    assign vo.line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-width lines with a shortened frame, outputs
// compared every cycle against an arithmetic raster model plus interval checks.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int HA  = 720;
    localparam int HFP = 16;
    localparam int HSN = 62;
    localparam int HBP = 60;
    localparam int VA  = 12;
    localparam int VFP = 2;
    localparam int VSN = 3;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HSN + HBP;
    localparam int VT  = VA + VFP + VSN + VBP;
    localparam int FT  = HT * VT;

    localparam logic [24:0] RST_VEC = {~HS_POL, ~VS_POL, 23'b0};

    logic clk = 1'b0;
    logic rst_n;
    logic pll_lock;

    int checks = 0;
    int errors = 0;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .H_ACTIVE (HA),  .H_FP (HFP), .H_SYNC (HSN), .H_BP (HBP),
        .V_ACTIVE (VA),  .V_FP (VFP), .V_SYNC (VSN), .V_BP (VBP),
        .HS_POL   (HS_POL), .VS_POL (VS_POL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .vo       (vif)
    );

    always #5 clk = ~clk;

    logic [24:0] obs;
    assign obs = {vif.hsync, vif.vsync, vif.de, vif.x, vif.y, vif.frame_start, vif.line_start};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs t cycles after the first frame_start of a raster.
    function automatic logic [24:0] exp_out(input int t);
        int   h, v;
        logic de, hs, vs;
        h  = t % HT;
        v  = (t / HT) % VT;
        de = (h < HA) && (v < VA);
        hs = (h >= HA + HFP && h < HA + HFP + HSN) ? HS_POL : ~HS_POL;
        vs = (v >= VA + VFP && v < VA + VFP + VSN) ? VS_POL : ~VS_POL;
        return {hs, vs, de, de ? 10'(h) : 10'd0, de ? 10'(v) : 10'd0,
                (h == 0 && v == 0), (h == 0)};
    endfunction

    task automatic lock_and_wait(input string tag);
        int n;
        n = 0;
        pll_lock = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (vif.frame_start) begin
                n = i;
                break;
            end
        end
        chk(tag, n, 4);
    endtask

    task automatic run_stream(input int t0, input int t1, input bit here, input bit stats);
        int ls_a, ls_b, fs2, de_tot, de_run, de_run1, hs_fall, hs_len, vs_fall, vs_len;
        logic prev_hs;
        ls_a = -1; ls_b = -1; fs2 = -1; de_tot = 0; de_run = 0; de_run1 = -1;
        hs_fall = -1; hs_len = 0; vs_fall = -1; vs_len = 0; prev_hs = ~HS_POL;
        for (int t = t0; t < t1; t++) begin
            if (!(t == t0 && here)) @(negedge clk);
            chk("raster", obs, exp_out(t));
            if (stats) begin
                if (vif.line_start) begin
                    if (ls_a < 0) ls_a = t;
                    else if (ls_b < 0) ls_b = t;
                end
                if (vif.frame_start && t > 0 && fs2 < 0) begin
                    fs2 = t;
                    chk("next_frame_xy", {vif.de, vif.x, vif.y}, {1'b1, 20'd0});
                end
                if (vif.de) de_run++;
                else begin
                    if (de_run > 0 && de_run1 < 0) de_run1 = de_run;
                    de_run = 0;
                end
                if (t < FT) begin
                    de_tot += int'(vif.de);
                    if (vif.vsync == VS_POL) vs_len++;
                end
                if (vif.vsync == VS_POL && vs_fall < 0) vs_fall = t;
                if (t < HT) begin
                    if (vif.hsync == HS_POL) hs_len++;
                    if (prev_hs != HS_POL && vif.hsync == HS_POL && hs_fall < 0) hs_fall = t;
                    prev_hs = vif.hsync;
                end
                if (t == (VA - 1) * HT + HA - 1)
                    chk("last_pixel", {vif.de, vif.x, vif.y}, {1'b1, 10'(HA - 1), 10'(VA - 1)});
                if (t == (VA - 1) * HT + HA)
                    chk("after_last", {vif.de, vif.x, vif.y}, 21'd0);
            end
        end
        if (stats) begin
            chk("line_period", ls_b - ls_a, HT);
            chk("de_run", de_run1, HA);
            chk("hs_fall", hs_fall, HA + HFP);
            chk("hs_len", hs_len, HSN);
            chk("frame_period", fs2, FT);
            chk("de_per_frame", de_tot, HA * VA);
            chk("vs_len", vs_len, VSN * HT);
            chk("vs_fall", vs_fall, (VA + VFP) * HT);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

    initial begin
        int ld, pd, tdrop;
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outputs", obs, RST_VEC);
        chk("rst_syncs_high", {vif.hsync, vif.vsync}, 2'b11);

        pll_lock = 1'b0;
        rst_n    = 1'b1;
        repeat ($urandom_range(3, 10)) @(negedge clk);
        chk("parked", obs, RST_VEC);

        lock_and_wait("startup_latency");
        run_stream(0, FT + 2 * HT, 1'b1, 1'b1);

        // Drop lock at a random active pixel in the second frame.
        ld    = $urandom_range(1, VA - 1);
        pd    = $urandom_range(1, HA - 1);
        tdrop = FT + ld * HT + pd;
        run_stream(FT + 2 * HT, tdrop + 1, 1'b0, 1'b0);
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("lockloss_reset", obs, RST_VEC);
        repeat ($urandom_range(2, 20)) @(negedge clk);
        chk("lockloss_parked", obs, RST_VEC);

        lock_and_wait("relock_latency");
        run_stream(0, 2 * HT + 5, 1'b1, 1'b0);

        // Asynchronous reset mid-line, well away from a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", obs, RST_VEC);
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
